// File: rtl/vec_load_collector.sv
// Vector-load collector: issues one strided scalar read per element and
// gathers the in-order responses into a vector for writeback.
module vec_load_collector #(
  parameter int DATA_W = 16,
  parameter int LANES  = 16,
  parameter int RD_W   = 5,
  parameter int ADDR_W = 16,
  parameter int MAX_OUT = 4,
  parameter int VLEN_W = $clog2(LANES + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [RD_W-1:0]         rd_in,
  input  logic [ADDR_W-1:0]       base_addr,
  input  logic [ADDR_W-1:0]       stride,
  input  logic [VLEN_W-1:0]       vlen,
  input  logic                    reverse,
  output logic                    busy,
  output logic                    mem_req,
  output logic [ADDR_W-1:0]       mem_addr,
  input  logic                    mem_ready,
  input  logic                    mem_rvalid,
  input  logic [DATA_W-1:0]       mem_rdata,
  output logic                    wb_valid,
  input  logic                    wb_ready,
  output logic [RD_W-1:0]         wb_rd,
  output logic [LANES*DATA_W-1:0] wb_data
);

  localparam int OUT_W = $clog2(MAX_OUT + 1);
  localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int VW    = LANES * DATA_W;
  localparam logic [OUT_W-1:0]  MAX_O = OUT_W'(MAX_OUT);
  localparam logic [VLEN_W-1:0] VMAX  = VLEN_W'(LANES);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, WB} state_t;

  state_t            state, state_n;
  logic [VLEN_W-1:0] issue_cnt, issue_n;
  logic [VLEN_W-1:0] rcv_cnt, rcv_n;
  logic [VLEN_W-1:0] vlen_q, vlen_n, vclamp;
  logic [OUT_W-1:0]  outst, outst_n;
  logic [RD_W-1:0]   rd_q, rd_n, wb_rd_n;
  logic              rev_q, rev_n;
  logic [ADDR_W-1:0] stride_q, stride_n, addr_n;
  logic [VW-1:0]     acc, acc_n, wb_data_n;
  logic              req_n, wbv_n, busy_n;
  logic              fire, rsp;
  logic [LW-1:0]     lane;

  always_comb begin
    state_n   = state;
    issue_n   = issue_cnt;
    rcv_n     = rcv_cnt;
    vlen_n    = vlen_q;
    outst_n   = outst;
    rd_n      = rd_q;
    rev_n     = rev_q;
    stride_n  = stride_q;
    acc_n     = acc;
    addr_n    = mem_addr;
    req_n     = mem_req;
    wbv_n     = wb_valid;
    wb_rd_n   = wb_rd;
    wb_data_n = wb_data;
    vclamp = (vlen > VMAX) ? VMAX : vlen;
    fire   = mem_req && mem_ready;
    rsp    = mem_rvalid && (outst != '0)
          && (state == ISSUE || state == DRAIN);
    lane   = rev_q ? LW'(LANES - 1) - rcv_cnt[LW-1:0]
                   : rcv_cnt[LW-1:0];
    unique case (state)
      IDLE: begin
        if (start) begin
          rd_n     = rd_in;
          rev_n    = reverse;
          vlen_n   = vclamp;
          stride_n = stride;
          acc_n    = '0;
          issue_n  = '0;
          rcv_n    = '0;
          outst_n  = '0;
          if (vclamp == '0) begin
            state_n   = WB;
            wbv_n     = 1'b1;
            wb_data_n = '0;
            wb_rd_n   = rd_in;
          end else begin
            state_n = ISSUE;
            req_n   = 1'b1;
            addr_n  = base_addr;
          end
        end
      end
      ISSUE, DRAIN: begin
        if (fire) begin
          issue_n = issue_cnt + 1'b1;
          addr_n  = mem_addr + stride_q;
        end
        if (rsp) begin
          acc_n[lane*DATA_W +: DATA_W] = mem_rdata;
          rcv_n = rcv_cnt + 1'b1;
        end
        outst_n = outst + OUT_W'(fire) - OUT_W'(rsp);
        // completion wins; otherwise throttle on the outstanding limit
        if (rcv_n == vlen_q) begin
          state_n   = WB;
          req_n     = 1'b0;
          wbv_n     = 1'b1;
          wb_data_n = acc_n;
          wb_rd_n   = rd_q;
        end else if (issue_n == vlen_q) begin
          state_n = DRAIN;
          req_n   = 1'b0;
        end else begin
          req_n = (outst_n != MAX_O);
        end
      end
      WB: begin
        if (wb_ready) begin
          wbv_n   = 1'b0;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      issue_cnt <= '0;
      rcv_cnt   <= '0;
      vlen_q    <= '0;
      outst     <= '0;
      rd_q      <= '0;
      rev_q     <= 1'b0;
      stride_q  <= '0;
      acc       <= '0;
      busy      <= 1'b0;
      mem_req   <= 1'b0;
      mem_addr  <= '0;
      wb_valid  <= 1'b0;
      wb_rd     <= '0;
      wb_data   <= '0;
    end else begin
      state     <= state_n;
      issue_cnt <= issue_n;
      rcv_cnt   <= rcv_n;
      vlen_q    <= vlen_n;
      outst     <= outst_n;
      rd_q      <= rd_n;
      rev_q     <= rev_n;
      stride_q  <= stride_n;
      acc       <= acc_n;
      busy      <= busy_n;
      mem_req   <= req_n;
      mem_addr  <= addr_n;
      wb_valid  <= wbv_n;
      wb_rd     <= wb_rd_n;
      wb_data   <= wb_data_n;
    end
  end

endmodule

// File: tb/tb_vec_load_collector.sv
// Bench for vec_load_collector: in-order latency memory, vector model,
// per-cycle compare process and directed command table.
module tb_vec_load_collector;

  localparam int DW  = 16;
  localparam int LN  = 16;
  localparam int RW  = 5;
  localparam int AW  = 16;
  localparam int MO  = 2;
  localparam int VW  = LN * DW;
  localparam int VLW = $clog2(LN + 1);

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start = 1'b0;
  logic [RW-1:0]  rd_in = '0;
  logic [AW-1:0]  base_addr = '0;
  logic [AW-1:0]  stride = '0;
  logic [VLW-1:0] vlen = '0;
  logic           reverse = 1'b0;
  logic           busy, mem_req, wb_valid;
  logic [AW-1:0]  mem_addr;
  logic           mem_ready, mem_rvalid;
  logic [DW-1:0]  mem_rdata;
  logic           wb_ready = 1'b0;
  logic [RW-1:0]  wb_rd;
  logic [VW-1:0]  wb_data;

  vec_load_collector #(
    .DATA_W(DW), .LANES(LN), .RD_W(RW), .ADDR_W(AW), .MAX_OUT(MO)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .rd_in(rd_in),
    .base_addr(base_addr), .stride(stride), .vlen(vlen),
    .reverse(reverse), .busy(busy), .mem_req(mem_req),
    .mem_addr(mem_addr), .mem_ready(mem_ready),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd),
    .wb_data(wb_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [VW-1:0] act,
                     input logic [VW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // model of the current command
  logic [AW-1:0] exp_addr[$];
  logic [VW-1:0] exp_vec;
  logic [RW-1:0] exp_rd;
  int            t0;

  // observations
  logic [AW-1:0] acc_log[$];
  int            n_acc, outst_m, max_out_seen;
  int            first_req_rel, wb_rise_rel, wb_hi_cycles;
  logic [VW-1:0] cap_data;
  bit            mbusy, prev_stall, prev_hold, prev_wbv;
  logic [AW-1:0] prev_addr;
  logic [VW-1:0] prev_data;
  logic [RW-1:0] prev_rd;

  // memory: fixed latency, in-order, optional random ready
  typedef struct {logic [AW-1:0] a; int due;} rsp_t;
  rsp_t mq[$];
  int   lat = 1;
  bit   rdy_rand = 1'b0;

  initial begin
    mem_ready  = 1'b1;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    forever begin
      @(posedge clk);
      #1;
      mem_rvalid = 1'b0;
      mem_rdata  = '0;
      if (!rst && mq.size() > 0 && mq[0].due == cyc) begin
        mem_rvalid = 1'b1;
        mem_rdata  = 16'hA000 + mq[0].a;
        void'(mq.pop_front());
      end
      mem_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (rst) mq.delete();
      else if (mem_req && mem_ready)
        mq.push_back('{mem_addr, cyc + lat});
    end
  end

  // per-cycle compare
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        n_acc = 0; outst_m = 0; mbusy = 0;
        prev_stall = 0; prev_hold = 0; prev_wbv = 0;
      end else begin
        chk("busy", busy, mbusy);
        if (prev_stall) begin
          chk("req_held", mem_req, 1);
          chk("addr_held", mem_addr, prev_addr);
        end
        if (mem_req) begin
          if (first_req_rel < 0) first_req_rel = cyc - t0;
          if (n_acc < exp_addr.size())
            chk("mem_addr", mem_addr, exp_addr[n_acc]);
          else
            chk("extra_req", n_acc, exp_addr.size());
        end
        if (mem_req && mem_ready) begin
          acc_log.push_back(mem_addr);
          n_acc++;
          outst_m++;
        end
        if (mem_rvalid && outst_m > 0) outst_m--;
        if (outst_m > max_out_seen) max_out_seen = outst_m;
        if (mbusy) chk("outstanding_limit", outst_m > MO, 0);
        if (prev_hold) begin
          chk("wb_valid_held", wb_valid, 1);
          chk("wb_data_held", wb_data, prev_data);
          chk("wb_rd_held", wb_rd, prev_rd);
        end
        if (wb_valid) begin
          wb_hi_cycles++;
          if (!prev_wbv) begin
            wb_rise_rel = cyc - t0;
            cap_data = wb_data;
            chk("wb_data", wb_data, exp_vec);
            chk("wb_rd", wb_rd, exp_rd);
            chk("req_count", n_acc, exp_addr.size());
          end
        end
        prev_stall = mem_req && !mem_ready;
        prev_addr  = mem_addr;
        prev_hold  = wb_valid && !wb_ready;
        prev_wbv   = wb_valid;
        prev_data  = wb_data;
        prev_rd    = wb_rd;
        if (mbusy) begin
          if (wb_valid && wb_ready) mbusy = 0;
        end else if (start) begin
          mbusy = 1;
        end
      end
    end
  end

  task automatic start_cmd(input logic [RW-1:0] r, input logic [AW-1:0] b,
                           input logic [AW-1:0] s, input int vl,
                           input bit rv);
    int n;
    logic [AW-1:0] a;
    @(posedge clk);
    #1;
    n = (vl > LN) ? LN : vl;
    exp_addr.delete();
    acc_log.delete();
    exp_vec = '0;
    exp_rd  = r;
    for (int k = 0; k < n; k++) begin
      a = b + AW'(k) * s;
      exp_addr.push_back(a);
      exp_vec[(rv ? LN - 1 - k : k) * DW +: DW] = 16'hA000 + a;
    end
    n_acc = 0; max_out_seen = 0;
    first_req_rel = -1; wb_rise_rel = -1; wb_hi_cycles = 0;
    t0 = cyc;
    rd_in = r; base_addr = b; stride = s;
    vlen = VLW'(vl); reverse = rv; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    rd_in = ~r;
  endtask

  task automatic pulse_start();
    @(posedge clk);
    #1;
    start = 1'b1;
    base_addr = 16'h7777;
    rd_in = 5'h1F;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic finish_cmd(input int hold);
    int t;
    wb_ready = (hold == 0);
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!wb_valid && t < 200);
    chk("wb_timeout", wb_valid, 1);
    if (hold > 0) begin
      repeat (hold) @(posedge clk);
      #1;
      wb_ready = 1'b1;
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    wb_ready = 1'b0;
  endtask

  initial begin
    int t;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_wb_rd", wb_rd, 0);
    chk("rst_wb_data", wb_data, 0);
    rst = 1'b0;

    // full vector, ascending, unit stride
    start_cmd(5'h0A, 16'h0100, 16'h0001, 16, 0);
    finish_cmd(0);
    chk("t1_first_req", first_req_rel, 1);
    chk("t1_wb_rise", wb_rise_rel, 18);
    chk("t1_lane0", cap_data[0 +: DW], 16'hA100);
    chk("t1_lane15", cap_data[15*DW +: DW], 16'hA10F);
    chk("t1_wb_cycles", wb_hi_cycles, 1);

    // reversed fill, negative stride with wrap
    start_cmd(5'h13, 16'h0003, 16'hFFFE, 4, 1);
    finish_cmd(0);
    chk("t2_addr2", acc_log[2], 16'hFFFF);
    chk("t2_addr3", acc_log[3], 16'hFFFD);
    chk("t2_lane15", cap_data[15*DW +: DW], 16'hA003);
    chk("t2_lane13", cap_data[13*DW +: DW], 16'h9FFF);
    chk("t2_lane12", cap_data[12*DW +: DW], 16'h9FFD);
    chk("t2_low_zero", cap_data[12*DW-1:0], 0);
    chk("t2_wb_rise", wb_rise_rel, 6);

    // long latency hits the outstanding limit
    lat = 5;
    start_cmd(5'h07, 16'h0040, 16'h0003, 8, 0);
    finish_cmd(0);
    chk("t3_max_out", max_out_seen, 2);
    chk("t3_accepts", n_acc, 8);

    // random stalls, ignored starts, writeback backpressure
    lat = 2;
    rdy_rand = 1'b1;
    start_cmd(5'h1C, 16'h1000, 16'h0010, 8, 0);
    pulse_start();
    finish_cmd(3);
    rdy_rand = 1'b0;
    chk("t4_wb_cycles", wb_hi_cycles, 4);

    // empty command
    lat = 1;
    start_cmd(5'h01, 16'h5555, 16'h0001, 0, 0);
    finish_cmd(0);
    chk("t5_wb_rise", wb_rise_rel, 1);
    chk("t5_no_req", first_req_rel, -1);
    chk("t5_zero_data", cap_data, 0);

    // oversize count clamps to LANES
    start_cmd(5'h02, 16'h2000, 16'h0001, 20, 1);
    finish_cmd(0);
    chk("t5_clamp_accepts", n_acc, 16);
    chk("t5_clamp_wb_rise", wb_rise_rel, 18);

    // reset in the middle of issue
    start_cmd(5'h04, 16'h0200, 16'h0001, 16, 0);
    t = 0;
    while (n_acc < 5 && t < 100) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("t6_reached_5", n_acc, 5);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_busy", busy, 0);
    chk("t6_mem_req", mem_req, 0);
    chk("t6_wb_valid", wb_valid, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    start_cmd(5'h0F, 16'h0300, 16'h0002, 6, 1);
    finish_cmd(1);
    chk("t6_after_wb_rise", wb_rise_rel, 8);
    chk("t6_after_lane15", cap_data[15*DW +: DW], 16'hA300);

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vec_load_collector.md
Name: vec_load_collector

Overview:
- Parametrised vector-load collector for the memory stage.
- Takes a vector-load command: destination register, base address, stride, element count and fill order.
- Issues one scalar memory read per element through a request/ready handshake and gathers the in-order read responses into a LANES x DATA_W vector.
- Presents the finished vector plus destination register to writeback through a valid/ready handshake.

Parameters:
DATA_W, 16, width of one memory word / vector lane
LANES, 16, lanes per vector register
RD_W, 5, destination register index width
ADDR_W, 16, memory word-address width
MAX_OUT, 4, maximum outstanding (accepted but unanswered) read requests; must be >= 1
VLEN_W, $clog2(LANES+1), width of element-count input (derived)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
start  in  1  command strobe, sampled only in IDLE
rd_in  in  RD_W  destination register of command
base_addr  in  ADDR_W  address of element 0
stride  in  ADDR_W  address increment per element (two's complement, modulo 2^ADDR_W)
vlen  in  VLEN_W  element count; values > LANES clamp to LANES
reverse  in  1  0: element k -> lane k; 1: element k -> lane LANES-1-k (legacy descending fill)
busy  out  1  high whenever state != IDLE
mem_req  out  1  read request valid
mem_addr  out  ADDR_W  read address
mem_ready  in  1  memory accepts request when mem_req && mem_ready
mem_rvalid  in  1  read data valid; responses return in request order
mem_rdata  in  DATA_W  read data
wb_valid  out  1  collected vector valid
wb_ready  in  1  writeback accepts when wb_valid && wb_ready
wb_rd  out  RD_W  destination register
wb_data  out  LANES*DATA_W  packed vector; lane i = bits [i*DATA_W +: DATA_W]

Behaviour:
- Reset values: state IDLE; busy 0, mem_req 0, mem_addr 0, wb_valid 0, wb_rd 0, wb_data 0; all internal counters 0.
- All outputs are registered.
- States: IDLE, ISSUE, DRAIN, WB.
- IDLE + start:
  - Latch rd_in, reverse and clamped vlen.
  - Clear the vector accumulator to all zeros, so unfilled lanes read 0.
  - issue_cnt = rcv_cnt = outstanding = 0.
  - If clamped vlen == 0, go to WB (wb_valid=1, wb_data all zero, no memory traffic).
  - Otherwise go to ISSUE with mem_req=1 and mem_addr=base_addr.
  - start is ignored in every state other than IDLE.
- ISSUE:
  - An accepted request (mem_req && mem_ready) increments issue_cnt and outstanding, and advances mem_addr by stride (wraps modulo 2^ADDR_W).
  - mem_req is held high with a stable mem_addr until accepted.
  - mem_req deasserts while outstanding == MAX_OUT (after counting a same-cycle response).
  - When issue_cnt reaches vlen, mem_req drops and the state goes to DRAIN.
- Responses (ISSUE or DRAIN): mem_rvalid writes mem_rdata into lane rcv_cnt (or LANES-1-rcv_cnt if reverse), increments rcv_cnt and decrements outstanding.
- Same-cycle accept and response: outstanding is unchanged.
- Completion: when rcv_cnt reaches vlen, go to WB.
  - wb_valid=1 and wb_data = accumulator including the final word.
  - wb_rd = latched rd.
- WB:
  - wb_valid, wb_rd and wb_data are held stable until wb_ready.
  - On handshake, wb_valid=0 and the state returns to IDLE.
  - A new start is accepted no earlier than the cycle after the handshake.
- mem_rvalid outside ISSUE/DRAIN is ignored. mem_rvalid with outstanding == 0 is ignored.
- Latency with mem_ready=1, 1-cycle read latency, MAX_OUT >= 2, start sampled at cycle 0:
  - mem_req high from cycle 1.
  - Request k is accepted at cycle 1+k.
  - wb_valid rises at cycle vlen+2.
- Reset mid-operation: immediate return to IDLE with reset values. The system must also reset the memory so stale responses are not delivered afterwards.

Test Plan:
- LANES=16, base=0x0100, stride=1, vlen=16, reverse=0, mem_rdata = 0xA000 + address, 1-cycle latency, wb_ready=1 -> mem_addr 0x0100..0x010F on cycles 1..16; wb_valid only at cycle 18; lane i = 0xA100+i; wb_rd = rd_in.
- Same stream with reverse=1, vlen=4, stride=0xFFFE (-2), base=0x0003 -> addresses 0x0003, 0x0001, 0xFFFF, 0xFFFD (wrap); lanes 15..12 hold the four words; lanes 11..0 = 0.
- MAX_OUT=2, mem_ready=1, read latency 5 -> mem_req drops after 2 accepts; at most 2 outstanding at any cycle; all 8 words of vlen=8 land in correct lanes.
- Random mem_ready stalls plus wb_ready held low 3 cycles -> mem_addr stable while stalled; wb_valid/wb_data stable 3 cycles; start pulses during busy ignored; busy falls the cycle after handshake.
- vlen=0 -> no mem_req; wb_valid at cycle 1 with zero data. vlen=20 on LANES=16 -> exactly 16 requests.
- rst asserted at issue_cnt=5 -> next edge: busy=0, mem_req=0, wb_valid=0. A subsequent clean command completes correctly.
